// File: rtl/int_ctrl_pkg.sv
// Shared constants for the int_ctrl interrupt aggregator.
// Software register headers mirror this package.
package int_ctrl_pkg;

   localparam int INT_BUS_W = 8;

   localparam logic [7:0] OFF_PENDING = 8'h00;
   localparam logic [7:0] OFF_ENABLE  = 8'h04;
   localparam logic [7:0] OFF_TYPE    = 8'h08;
   localparam logic [7:0] OFF_CLEAR   = 8'h0C;
   localparam logic [7:0] OFF_ID      = 8'h10;
   localparam logic [7:0] OFF_CTRL    = 8'h14;

   localparam int ID_VALID_BIT = 31;
   localparam int GIE_BIT      = 0;

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder.
// Produces {valid, index} for the claim-ID register.
module int_ctrl_prio_enc #(
   parameter int N = 8
) (
   input  logic [N-1:0] req_i,
   output logic         valid_o,
   output logic [2:0]   idx_o
);

   always_comb begin
      valid_o = 1'b0;
      idx_o   = 3'd0;
      // Scan downward so the lowest set index is written last
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            valid_o = 1'b1;
            idx_o   = 3'(i);
         end
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// RIB-mapped interrupt aggregator: level/edge latch, mask, claim ID.
// Define INT_CTRL_SYNC_EN to add a 2-flop synchronizer on src_i.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we_i,
   input  logic [31:0]          addr_i,
   input  logic [31:0]          data_i,
   output logic [31:0]          data_o,
   input  logic [NUM_SRC-1:0]   src_i,
   output logic [INT_BUS_W-1:0] int_o,
   output logic                 irq_o
);

   logic [NUM_SRC-1:0] src_v;
   logic [NUM_SRC-1:0] src_q;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] enable_q, enable_d;
   logic [NUM_SRC-1:0] type_q, type_d;
   logic               gie_q, gie_d;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] clr;
   logic [NUM_SRC-1:0] masked;
   logic               id_valid;
   logic [2:0]         id_idx;
   logic [7:0]         off;
   logic               unused_bits;

   assign off         = addr_i[7:0];
   assign unused_bits = ^{addr_i[31:8], data_i[31:NUM_SRC]};

`ifdef INT_CTRL_SYNC_EN
   logic [NUM_SRC-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= src_i;
         sync2_q <= sync1_q;
      end
   end

   assign src_v = sync2_q;
`else
   assign src_v = src_i;
`endif

   assign rise = src_v & ~src_q;
   assign clr  = (we_i && off == OFF_CLEAR) ?
                 data_i[NUM_SRC-1:0] : '0;

   always_comb begin
      enable_d = enable_q;
      type_d   = type_q;
      gie_d    = gie_q;
      if (we_i && off == OFF_ENABLE) enable_d = data_i[NUM_SRC-1:0];
      if (we_i && off == OFF_TYPE)   type_d   = data_i[NUM_SRC-1:0];
      if (we_i && off == OFF_CTRL)   gie_d    = data_i[GIE_BIT];
      // Edge: a rise beats a same-cycle clear. Level: follow the line.
      pending_d = (type_q & (rise | (pending_q & ~clr)))
                | (~type_q & src_v);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_q     <= '0;
         pending_q <= '0;
         enable_q  <= '0;
         type_q    <= '0;
         gie_q     <= 1'b0;
      end else begin
         src_q     <= src_v;
         pending_q <= pending_d;
         enable_q  <= enable_d;
         type_q    <= type_d;
         gie_q     <= gie_d;
      end
   end

   assign masked = pending_q & enable_q & {NUM_SRC{gie_q}};

   int_ctrl_prio_enc #(
      .N(NUM_SRC)
   ) u_prio (
      .req_i  (masked),
      .valid_o(id_valid),
      .idx_o  (id_idx)
   );

   always_comb begin
      int_o = '0;
      int_o[NUM_SRC-1:0] = masked;
      irq_o = |masked;
   end

   always_comb begin
      data_o = '0;
      case (off)
         OFF_PENDING: data_o[NUM_SRC-1:0] = pending_q;
         OFF_ENABLE:  data_o[NUM_SRC-1:0] = enable_q;
         OFF_TYPE:    data_o[NUM_SRC-1:0] = type_q;
         OFF_ID: begin
            data_o[ID_VALID_BIT] = id_valid;
            data_o[2:0]          = id_idx;
         end
         OFF_CTRL:    data_o[GIE_BIT] = gie_q;
         default:     ;
      endcase
   end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Memory-mapped interrupt aggregator on the RIB bus, placed directly upstream of the core's `int_i` input. It collects the raw peripheral interrupt lines: timer0, UART SID-done, I2C complete and GPIO-derived lines. Each source is latched as level or rising-edge, then masked. The block drives the core's interrupt bus and exposes pending and claim-ID state to software, which replaces the hard-wired `{7'h0, timer0_int}` concatenation.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources; 1..8. It is bounded by the `INT_BUS` width.
- `clk`  in  1: system clock. This is the only clock.
- `rst`  in  1: reset, asynchronous, active-high. All flops clear immediately on assertion.
- `we_i`  in  1: RIB write strobe from the slave port.
- `addr_i`  in  32: RIB address. Only `addr_i[7:0]` is decoded; slot selection is done by `rib`.
- `data_i`  in  32: write data.
- `data_o`  out  32: read data. It is combinational from registers and addr_i.
- `src_i`  in  NUM_SRC: raw interrupt lines, active-high.
- `int_o`  out  8: to core `int_i`. It equals `pending & enable` when GIE=1, else 0; bits above NUM_SRC are 0.
- `irq_o`  out  1: OR of `int_o`.

## Operation
Registers are word-wide. Only whole-word writes are supported. Unmapped offsets read 0, and writes to them are ignored.

- 0x00 PENDING (RO): `pending[NUM_SRC-1:0]`.
- 0x04 ENABLE (RW): per-source mask. Reset value is 0.
- 0x08 TYPE (RW): per source, 1 = rising-edge and 0 = level. Reset value is 0.
- 0x0C CLEAR (WO, W1C): a 1 clears the pending bit of an edge source. It has no effect on level sources. Reads return 0.
- 0x10 ID (RO):
  - bit31 = valid, bits[2:0] = lowest index with `pending & enable`.
  - It reads 0 when no such index exists or when GIE=0.
  - Lowest index has highest priority.
- 0x14 CTRL (RW): bit0 = GIE (global enable); reset value is 0. Other bits read 0.

Source handling, per clock, for each source i:
- `src_q[i] <= src_i[i]`, and `rise[i] = src_i[i] & ~src_q[i]`.
- Edge source: `pending[i] <= rise[i] | (pending[i] & ~clr[i])`. Set wins over a simultaneous CLEAR.
- Level source: `pending[i] <= src_i[i]`. It is not software-clearable.
- Changing TYPE from edge to level takes effect on the next edge. The pending bit then follows the level.
- ENABLE masks only the outputs. Pending bits still capture events while a source is disabled.

No state machine beyond per-source latch state.

## Timing
Reset values:
- All registers, `src_q` and `pending` are 0 at reset.
- `int_o` = 0, `irq_o` = 0 and `data_o` = 0 at reset.
- Asserting `rst` mid-operation drops `int_o` in the same cycle, asynchronously.

Latencies:
- Source-to-output latency is 1 clock. A rise of `src_i` sampled at edge N sets `pending` at edge N, and `int_o` is valid after edge N.
- Register write latency is 1 clock. A write at edge N affects `int_o`, `ID` and `data_o` after edge N.
- A CLEAR write at edge N removes the bit after edge N, unless a new rise is sampled at the same edge.
- Edge detection requires a low cycle between pulses. A source held high produces exactly one event.
- A 1-cycle pulse on `src_i` is always caught, because edge sources latch.

## Configuration
- `INT_CTRL_SYNC_EN` defined:
  - `src_i` passes through a 2-flop synchronizer, reset value 0, before edge detect and the level path.
  - Source-to-output latency becomes 3 clocks.
  - Use this setting for GPIO or pad-sourced lines.
- `INT_CTRL_SYNC_EN` undefined: `src_i` is used directly. All sources must already be synchronous to `clk`.

## Structure
- Register offsets (0x00..0x14), the ID valid bit position and the GIE bit position are defined as constants in a shared package `int_ctrl_pkg`. Software headers mirror this package.
- The sub-module `int_ctrl_prio_enc` is a parameterized lowest-index priority encoder from NUM_SRC bits to {valid, index[2:0]}. It produces the ID register value.
- The top of `int_ctrl` holds the register file, the optional synchronizer, edge detect and pending logic.

## Test plan
1. Reset:
   - Stimulus: assert `rst` asynchronously between clock edges.
   - Required response: `int_o`=0x00, `irq_o`=0, and all registers read 0.
2. Edge source:
   - Stimulus: GIE=1, ENABLE=0x01, TYPE=0x01, then a 1-cycle pulse on `src_i[0]`.
   - Required response: PENDING=0x01 and `int_o`=0x01 after the sampling edge, held after the pulse ends.
   - Then write CLEAR=0x01; required response: `int_o`=0x00 the next cycle.
3. Level source:
   - Stimulus: GIE=1, ENABLE=0x08, TYPE=0x00, `src_i[3]`=1 for 5 cycles.
   - Required response: `int_o`=0x08 for 5 cycles, 0 one cycle after the drop.
   - Then write CLEAR=0x08 while the source is high; required response: no effect.
4. Set/clear collision:
   - Stimulus: edge source 1 is pending, and a CLEAR=0x02 write coincides with a new rise on `src_i[1]`.
   - Required response: PENDING bit1 stays 1.
5. Priority:
   - Stimulus: sources 2 and 5 are enabled edge sources, both pending.
   - Required response: ID=0x8000_0002.
   - Then clear bit 2; required response: ID=0x8000_0005.
   - Then clear bit 5; required response: ID=0x0000_0000.
   - Then with GIE=0 and bits still pending; required response: `int_o`=0 and ID=0.
6. Masking and reset mid-operation:
   - Stimulus: a rise on source 4 while ENABLE=0.
   - Required response: PENDING=0x10, `int_o`=0.
   - Then enable it; required response: `int_o`=0x10 the next cycle.
   - Then assert `rst`; required response: all outputs 0 immediately.
